// File: rtl/ha_serial_add_sched_pkg.sv
// rtl/ha_serial_add_sched_pkg.sv - shared types and constants for the serial add sequencer
package ha_sched_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADD  = 2'd1,
      RESP = 2'd2
   } state_t;

   localparam int NUM_REQ = 2;

   // Bit counter width; counts 0..WIDTH-1 during ADD
   function automatic int cnt_width(input int w);
      return $clog2(w);
   endfunction

endpackage

// File: rtl/ha_serial_add_sched_if.sv
// rtl/ha_serial_add_sched_if.sv - request/response bundle between requesters and the sequencer
interface ha_serial_add_sched_if #(parameter int WIDTH = 8);
   import ha_sched_pkg::*;

   logic [NUM_REQ-1:0]       req_valid;
   logic [NUM_REQ-1:0]       req_ready;
   logic [NUM_REQ*WIDTH-1:0] req_a;
   logic [NUM_REQ*WIDTH-1:0] req_b;
   logic                     rsp_valid;
   logic                     rsp_ready;
   logic                     rsp_id;
   logic [WIDTH-1:0]         rsp_sum;
   logic                     rsp_cout;
   logic                     busy;

   modport master (
      output req_valid, req_a, req_b, rsp_ready,
      input  req_ready, rsp_valid, rsp_id, rsp_sum, rsp_cout, busy
   );

   modport slave (
      input  req_valid, req_a, req_b, rsp_ready,
      output req_ready, rsp_valid, rsp_id, rsp_sum, rsp_cout, busy
   );

endinterface

// File: rtl/ha_serial_add_sched_fa_cell.sv
// rtl/ha_serial_add_sched_fa_cell.sv - shared 1-bit full adder built from two half adders
module ha_cell (
   input  logic a,
   input  logic b,
   output logic s,
   output logic c
);
   assign s = a ^ b;
   assign c = a & b;
endmodule

module fa_cell (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic sum,
   output logic cout
);
   logic s1, c1, c2;

   ha_cell u_ha0 (.a(a),  .b(b),   .s(s1),  .c(c1));
   ha_cell u_ha1 (.a(s1), .b(cin), .s(sum), .c(c2));

   // Carry out of either half adder propagates
   assign cout = c1 | c2;
endmodule

// File: rtl/ha_serial_add_sched.sv
// rtl/ha_serial_add_sched.sv - round-robin sequencer time-sharing one adder cell bit-serially
module ha_serial_add_sched #(
   parameter int WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   ha_serial_add_sched_if.slave bus
);
   import ha_sched_pkg::*;

   localparam int CW = cnt_width(WIDTH);

   state_t           state;
   logic [WIDTH-1:0] a_sh;
   logic [WIDTH-1:0] b_sh;
   // Holds the low WIDTH-1 result bits; the final bit joins them on the last step
   logic [WIDTH-2:0] sum_sh;
   logic [WIDTH-1:0] sum_cat;
   logic             carry;
   logic [CW-1:0]    cnt;
   logic             last_grant;
   logic             grant;
   logic             grant_ok;
   logic             cell_s;
   logic             cell_c;

   fa_cell u_cell (
      .a   (a_sh[0]),
      .b   (b_sh[0]),
      .cin (carry),
      .sum (cell_s),
      .cout(cell_c)
   );

   assign sum_cat = {cell_s, sum_sh};

   // Arbiter: a lone requester wins, a tie goes to the one not served last
   always_comb begin
      grant = 1'b0;
      case (bus.req_valid)
         2'b01:   grant = 1'b0;
         2'b10:   grant = 1'b1;
         2'b11:   grant = ~last_grant;
         default: grant = 1'b0;
      endcase
   end

   // Grant only from IDLE; held low while reset is asserted so outputs clear at once
   assign grant_ok      = (state == IDLE) && (bus.req_valid != '0) && !rst;
   assign bus.req_ready = grant_ok ? {grant, ~grant} : 2'b00;
   assign bus.busy      = (state != IDLE);

   // Sequencer: accept, shift one bit per cycle through the cell, then hold the result
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= IDLE;
         a_sh          <= '0;
         b_sh          <= '0;
         sum_sh        <= '0;
         carry         <= 1'b0;
         cnt           <= '0;
         last_grant    <= 1'b1;
         bus.rsp_valid <= 1'b0;
         bus.rsp_id    <= 1'b0;
         bus.rsp_sum   <= '0;
         bus.rsp_cout  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (grant_ok) begin
                  a_sh       <= bus.req_a[int'(grant)*WIDTH +: WIDTH];
                  b_sh       <= bus.req_b[int'(grant)*WIDTH +: WIDTH];
                  bus.rsp_id <= grant;
                  carry      <= 1'b0;
                  cnt        <= '0;
                  state      <= ADD;
               end
            end
            ADD: begin
               a_sh   <= a_sh >> 1;
               b_sh   <= b_sh >> 1;
               sum_sh <= sum_cat[WIDTH-1:1];
               carry  <= cell_c;
               cnt    <= cnt + 1'b1;
               if (cnt == CW'(WIDTH - 1)) begin
                  bus.rsp_valid <= 1'b1;
                  bus.rsp_sum   <= sum_cat;
                  bus.rsp_cout  <= cell_c;
                  state         <= RESP;
               end
            end
            RESP: begin
               if (bus.rsp_ready) begin
                  bus.rsp_valid <= 1'b0;
                  last_grant    <= bus.rsp_id;
                  state         <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ha_serial_add_sched.sv
// tb/tb_ha_serial_add_sched.sv - scoreboard bench for the serial add sequencer
module tb_ha_serial_add_sched;
   localparam int WIDTH = 8;

   typedef struct packed {
      logic             id;
      logic [WIDTH-1:0] sum;
      logic             cout;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   int   n_checks = 0;
   int   n_fail = 0;
   int   cyc = 0;
   exp_t sb[$];

   ha_serial_add_sched_if #(.WIDTH(WIDTH)) bus ();

   ha_serial_add_sched #(.WIDTH(WIDTH)) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   // Free-running clock
   always #5 clk = ~clk;

   // Cycle counter used to measure issue spacing
   always @(posedge clk) cyc <= cyc + 1;

   function automatic exp_t mk(input logic id, input logic [WIDTH-1:0] s, input logic c);
      exp_t e;
      e.id = id;
      e.sum = s;
      e.cout = c;
      return e;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic fail_now(input string name);
      n_checks++;
      n_fail++;
      $display("FAIL %s: timed out waiting for DUT", name);
   endtask

   // Monitor: every response handshake is compared against the scoreboard head
   always @(negedge clk) begin
      exp_t e;
      if (!rst && bus.rsp_valid && bus.rsp_ready) begin
         if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_rsp: got id %0d sum 0x%0h, expected no response",
                     bus.rsp_id, bus.rsp_sum);
         end else begin
            e = sb.pop_front();
            chk("rsp_id", bus.rsp_id, e.id);
            chk("rsp_sum", bus.rsp_sum, e.sum);
            chk("rsp_cout", bus.rsp_cout, e.cout);
         end
      end
   end

   // Poll for a grant; on success ride through the accept edge and drop that request
   task automatic wait_grant(input int limit, output int g, output int waited, output int acc);
      g = -1;
      waited = 0;
      acc = 0;
      for (int k = 0; k < limit; k++) begin
         @(negedge clk);
         if (bus.req_ready != 2'b00) begin
            g = bus.req_ready[1] ? 1 : 0;
            break;
         end
         waited++;
      end
      if (g < 0) begin
         fail_now("grant_wait");
         g = 0;
      end else begin
         @(posedge clk);
         #1;
         acc = cyc;
         bus.req_valid[g] = 1'b0;
      end
   endtask

   task automatic wait_rsp(input int limit, output int edges);
      edges = -1;
      for (int k = 1; k <= limit; k++) begin
         @(posedge clk);
         #1;
         if (bus.rsp_valid) begin
            edges = k;
            break;
         end
      end
      if (edges < 0) fail_now("rsp_wait");
   endtask

   task automatic wait_drain(input int limit);
      int k;
      k = 0;
      while (sb.size() != 0 && k < limit) begin
         @(negedge clk);
         k++;
      end
      if (sb.size() != 0) fail_now("drain");
      @(posedge clk);
      #1;
   endtask

   // Watchdog
   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   // Directed stimulus
   initial begin
      int g, waited, acc, prev, edges;
      rst = 1'b1;
      bus.req_valid = '0;
      bus.req_a = '0;
      bus.req_b = '0;
      bus.rsp_ready = 1'b0;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      chk("rst_rsp_valid", bus.rsp_valid, 0);
      chk("rst_rsp_sum", bus.rsp_sum, 0);
      chk("rst_rsp_cout", bus.rsp_cout, 0);
      chk("rst_rsp_id", bus.rsp_id, 0);
      chk("rst_busy", bus.busy, 0);
      chk("rst_req_ready", bus.req_ready, 0);
      rst = 1'b0;
      @(negedge clk);
      chk("idle_busy", bus.busy, 0);
      chk("idle_req_ready", bus.req_ready, 0);

      // Single op with wrap: FF + 01
      @(posedge clk);
      #1;
      bus.rsp_ready = 1'b1;
      bus.req_a = {8'h00, 8'hFF};
      bus.req_b = {8'h00, 8'h01};
      bus.req_valid = 2'b01;
      sb.push_back(mk(1'b0, 8'h00, 1'b1));
      wait_grant(20, g, waited, acc);
      chk("t2_grant", g, 0);
      chk("t2_wait", waited, 0);
      chk("t2_busy", bus.busy, 1);
      wait_rsp(30, edges);
      chk("t2_latency", edges, WIDTH);
      wait_drain(40);

      // Fresh reset, then a tie: requester 0 first
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      bus.req_a = {8'h80, 8'h12};
      bus.req_b = {8'h80, 8'h34};
      bus.req_valid = 2'b11;
      sb.push_back(mk(1'b0, 8'h46, 1'b0));
      sb.push_back(mk(1'b1, 8'h00, 1'b1));
      wait_grant(40, g, waited, acc);
      chk("t3_first", g, 0);
      wait_grant(40, g, waited, acc);
      chk("t3_second", g, 1);
      wait_drain(40);

      // Fairness: both pending, grants alternate at WIDTH+2 spacing
      bus.req_a = {8'h7F, 8'h01};
      bus.req_b = {8'h01, 8'h02};
      bus.req_valid = 2'b11;
      sb.push_back(mk(1'b0, 8'h03, 1'b0));
      sb.push_back(mk(1'b1, 8'h80, 1'b0));
      sb.push_back(mk(1'b0, 8'h10, 1'b1));
      sb.push_back(mk(1'b1, 8'hFF, 1'b0));
      prev = 0;
      for (int i = 0; i < 4; i++) begin
         wait_grant(40, g, waited, acc);
         chk("t4_grant", g, i % 2);
         if (i > 0) chk("t4_spacing", acc - prev, WIDTH + 2);
         prev = acc;
         if (i == 0) begin
            bus.req_a[7:0] = 8'hF0;
            bus.req_b[7:0] = 8'h20;
            bus.req_valid[0] = 1'b1;
         end else if (i == 1) begin
            bus.req_a[15:8] = 8'hAA;
            bus.req_b[15:8] = 8'h55;
            bus.req_valid[1] = 1'b1;
         end
      end
      wait_drain(60);

      // Backpressure in RESP with a request waiting behind it
      bus.rsp_ready = 1'b0;
      bus.req_a = {8'h03, 8'h0F};
      bus.req_b = {8'h04, 8'h0F};
      bus.req_valid = 2'b01;
      sb.push_back(mk(1'b0, 8'h1E, 1'b0));
      sb.push_back(mk(1'b1, 8'h07, 1'b0));
      wait_grant(20, g, waited, acc);
      chk("t5_grant", g, 0);
      bus.req_valid[1] = 1'b1;
      wait_rsp(30, edges);
      chk("t5_latency", edges, WIDTH);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("t5_hold_valid", bus.rsp_valid, 1);
         chk("t5_hold_sum", bus.rsp_sum, 8'h1E);
         chk("t5_hold_ready", bus.req_ready, 0);
      end
      @(posedge clk);
      #1;
      bus.rsp_ready = 1'b1;
      wait_grant(20, g, waited, acc);
      chk("t5_next_grant", g, 1);
      chk("t5_next_wait", waited, 1);
      wait_drain(40);

      // Reset mid-ADD discards the op; the waiting requester 1 is served after
      bus.req_a = {8'hC8, 8'h55};
      bus.req_b = {8'h64, 8'h55};
      bus.req_valid = 2'b01;
      wait_grant(20, g, waited, acc);
      chk("t6_grant", g, 0);
      bus.req_valid[1] = 1'b1;
      repeat (3) @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      chk("t6_rst_valid", bus.rsp_valid, 0);
      chk("t6_rst_busy", bus.busy, 0);
      chk("t6_rst_sum", bus.rsp_sum, 0);
      chk("t6_rst_cout", bus.rsp_cout, 0);
      chk("t6_rst_ready", bus.req_ready, 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      sb.push_back(mk(1'b1, 8'h2C, 1'b1));
      wait_grant(20, g, waited, acc);
      chk("t6_regrant", g, 1);
      chk("t6_regrant_wait", waited, 0);
      wait_drain(40);

      repeat (3) @(posedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/ha_serial_add_sched.md
Name: ha_serial_add_sched

Overview:
Sequencer that time-shares one 1-bit adder cell between two requesters. The cell is built from two half adders plus carry-OR logic. Each accepted request adds two WIDTH-bit operands bit-serially, LSB first, using a carry register. Sits between the pin-level input capture and the output mux of the half-adder chip, replacing per-bit parallel adders with one shared cell.

Parameters:
WIDTH, 8, operand/sum width in bits (legal range 2..16)

Ports:
clk  input  1  single clock, rising edge
rst  input  1  asynchronous, active-high reset
req_valid  input  2  request valid per requester (bit 0 = requester 0)
req_ready  output  2  request accepted this cycle (at most one bit set)
req_a  input  2*WIDTH  operand A; requester r at [r*WIDTH +: WIDTH]
req_b  input  2*WIDTH  operand B; same packing as req_a
rsp_valid  output  1  result available
rsp_ready  input  1  consumer accepts result
rsp_id  output  1  requester that owns the result
rsp_sum  output  WIDTH  A+B modulo 2^WIDTH
rsp_cout  output  1  carry out of the MSB
busy  output  1  high in any state other than IDLE

Behaviour:
- Reset (async, active-high), forced immediately:
  - state=IDLE, req_ready=0, rsp_valid=0, rsp_id=0, rsp_sum=0, rsp_cout=0, busy=0
  - carry=0, bit counter=0, last_grant=1, so requester 0 wins the first tie
- FSM states: IDLE, ADD, RESP.
- IDLE:
  - Grant is combinational. If exactly one req_valid is set, grant that requester. If both are set, grant the requester != last_grant (round robin).
  - req_ready[g]=1 only for the granted requester and only in IDLE. Handshake = req_valid[g] & req_ready[g].
  - On handshake: latch A and B into shift registers, rsp_id<=g, carry<=0, cnt<=0, go to ADD.
  - Requests that are not granted see req_ready=0 and must hold.
- ADD, one bit per cycle:
  - s = a0^b0^carry, computed through the shared cell.
  - carry <= (a0&b0)|(carry&(a0^b0)).
  - Shift s into the sum register from the MSB side; shift A and B right.
  - cnt increments. When cnt==WIDTH-1, go to RESP and latch rsp_cout<=carry_next.
  - ADD lasts exactly WIDTH cycles. rsp_valid rises WIDTH clock edges after the accept edge.
- RESP:
  - rsp_valid=1. rsp_sum, rsp_cout and rsp_id stay stable until rsp_ready=1.
  - On rsp_valid&rsp_ready: rsp_valid<=0, last_grant<=rsp_id, go to IDLE.
  - No new request is accepted in the same cycle. Minimum issue interval is WIDTH+2 cycles.
- rsp_sum and rsp_cout hold their last values after the handshake, until the next RESP.
- Requests that arrive while busy are not dropped. They wait with req_ready=0.
- req_valid dropping before handshake is legal; no grant results and no state change occurs.
- Reset mid-ADD or mid-RESP: the in-flight operation is discarded and no response is issued. Requesters must re-request.
- Overflow wraps: sum = (A+B) mod 2^WIDTH, and cout carries bit WIDTH.

Decomposition:
- Package ha_sched_pkg holds:
  - state enum (IDLE=2'd0, ADD=2'd1, RESP=2'd2)
  - NUM_REQ=2
  - a localparam function for the counter width, $clog2(WIDTH)
- Sub-module fa_cell: combinational 1-bit full adder built from two half-adder instances plus an OR gate. It is the shared resource and is instantiated once.
- The arbiter, FSM, shift registers and carry register all live in the top block.

Test Plan:
1. Reset: assert rst mid-cycle with all inputs X-free -> all outputs 0 immediately. After release, busy=0 and req_ready=0 until a req_valid arrives.
2. Single op, WIDTH=8: req 0 with A=8'hFF, B=8'h01, rsp_ready=1 -> req_ready[0] on cycle 0; rsp_valid 8 edges later with rsp_sum=8'h00, rsp_cout=1, rsp_id=0.
3. Simultaneous requests after reset: req 0 (A=8'h12, B=8'h34) and req 1 (A=8'h80, B=8'h80) -> requester 0 served first (sum 8'h46, cout 0); requester 1 served next (sum 8'h00, cout 1, rsp_id=1).
4. Fairness: both requesters hold req_valid for 4 ops -> grants alternate 0,1,0,1. Each issue is spaced exactly WIDTH+2 cycles with rsp_ready=1.
5. Backpressure: rsp_ready=0 for 5 cycles in RESP with A=8'h0F, B=8'h0F -> rsp_valid stays 1 and rsp_sum stays 8'h1E throughout; req_ready stays 0; IDLE follows the cycle after rsp_ready=1.
6. Reset mid-ADD: assert rst at bit 3 of an op -> rsp_valid never rises for that op. After release, a pending req 1 is granted (last_grant reset to 1 gives priority to 0 only if both are valid).
